// File: rtl/local_store_responder.sv
// rtl/local_store_responder.sv - quadword local store shared by LSU and fetch ports
module local_store_responder #(
    parameter int LS_BYTES    = 32768,
    parameter int RD_LAT      = 6,
    parameter int MAX_LSU_RUN = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         lsu_req,
    input  logic         lsu_we,
    input  logic [14:0]  lsu_addr,
    input  logic [127:0] lsu_wdata,
    output logic         lsu_gnt,
    output logic         lsu_rvalid,
    output logic [127:0] lsu_rdata,
    input  logic         if_req,
    input  logic [14:0]  if_addr,
    output logic         if_gnt,
    output logic         if_rvalid,
    output logic [127:0] if_rdata,
    input  logic         flush
);

    localparam int DEPTH = LS_BYTES / 16;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int RUN_W = $clog2(MAX_LSU_RUN + 1);
    localparam int PIPE  = RD_LAT - 1;

    logic [127:0]     mem [DEPTH];
    logic [RUN_W-1:0] run_cnt;
    logic             run_full;
    logic             fetch_wait;
    logic [IDX_W-1:0] lsu_idx;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             acc_valid;
    logic             acc_port;
    logic             tail_v;
    logic             tail_p;
    logic [127:0]     tail_d;

    // Low four address bits select a byte inside the quadword and are ignored.
    wire unused_addr_bits = ^{lsu_addr[3:0], if_addr[3:0]};

    assign lsu_idx    = lsu_addr[4 +: IDX_W];
    assign if_idx     = if_addr[4 +: IDX_W];
    assign run_full   = (run_cnt == RUN_W'(MAX_LSU_RUN));
    assign fetch_wait = if_req && !flush;

    // LSU wins unless it has already taken MAX_LSU_RUN grants while fetch waited.
    assign lsu_gnt   = reset && lsu_req && !(fetch_wait && run_full);
    assign if_gnt    = reset && fetch_wait && !lsu_gnt;
    assign rd_idx    = if_gnt ? if_idx : lsu_idx;
    assign acc_valid = (lsu_gnt && !lsu_we) || if_gnt;
    assign acc_port  = if_gnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_cnt <= '0;
        end else if (if_gnt || !if_req) begin
            run_cnt <= '0;
        end else if (lsu_gnt && !run_full) begin
            run_cnt <= run_cnt + RUN_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (lsu_gnt && lsu_we) begin
            mem[lsu_idx] <= lsu_wdata;
        end
    end

    generate
        if (RD_LAT == 1) begin : g_direct
            assign tail_v = acc_valid;
            assign tail_p = acc_port;
            assign tail_d = mem[rd_idx];
        end else begin : g_pipe
            logic [PIPE-1:0] pv;
            logic [PIPE-1:0] pp;
            logic [127:0]    pd [PIPE];

            always_ff @(posedge clock) begin
                pd[0] <= mem[rd_idx];
                for (int i = 1; i < PIPE; i++) begin
                    pd[i] <= pd[i-1];
                end
            end

            // Port bit 1 marks a fetch entry; flush drops those as they advance.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    pv <= '0;
                    pp <= '0;
                end else begin
                    pv[0] <= acc_valid;
                    pp[0] <= acc_port;
                    for (int i = 1; i < PIPE; i++) begin
                        pv[i] <= pv[i-1] && !(flush && pp[i-1]);
                        pp[i] <= pp[i-1];
                    end
                end
            end

            assign tail_v = pv[PIPE-1] && !(flush && pp[PIPE-1]);
            assign tail_p = pp[PIPE-1];
            assign tail_d = pd[PIPE-1];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lsu_rvalid <= 1'b0;
            if_rvalid  <= 1'b0;
            lsu_rdata  <= '0;
            if_rdata   <= '0;
        end else begin
            lsu_rvalid <= tail_v && !tail_p;
            if_rvalid  <= tail_v && tail_p;
            if (tail_v && !tail_p) begin
                lsu_rdata <= tail_d;
            end
            if (tail_v && tail_p) begin
                if_rdata <= tail_d;
            end
        end
    end

endmodule

// File: tb/tb_local_store_responder.sv
// tb/tb_local_store_responder.sv - directed bench for local_store_responder
module tb_local_store_responder;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         lsu_req = 1'b0;
    logic         lsu_we = 1'b0;
    logic [14:0]  lsu_addr = '0;
    logic [127:0] lsu_wdata = '0;
    logic         lsu_gnt;
    logic         lsu_rvalid;
    logic [127:0] lsu_rdata;
    logic         if_req = 1'b0;
    logic [14:0]  if_addr = '0;
    logic         if_gnt;
    logic         if_rvalid;
    logic [127:0] if_rdata;
    logic         flush = 1'b0;

    local_store_responder dut (
        .clock      (clock),
        .reset      (reset),
        .lsu_req    (lsu_req),
        .lsu_we     (lsu_we),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_gnt    (lsu_gnt),
        .lsu_rvalid (lsu_rvalid),
        .lsu_rdata  (lsu_rdata),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .flush      (flush)
    );

    always #5 clock = ~clock;

    localparam logic [127:0] V1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] V2 = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
    localparam logic [127:0] DL = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] DF = 128'hF0F0F0F0_0F0F0F0F_A5A5A5A5_5A5A5A5A;
    localparam logic [127:0] X6 = 128'h66666666_77777777_88888888_99999999;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int lsu_rv_cyc[$];
    logic [127:0] lsu_rv_data[$];
    int if_rv_cyc[$];
    logic [127:0] if_rv_data[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (lsu_rvalid) begin
            lsu_rv_cyc.push_back(cyc);
            lsu_rv_data.push_back(lsu_rdata);
        end
        if (if_rvalid) begin
            if_rv_cyc.push_back(cyc);
            if_rv_data.push_back(if_rdata);
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        lsu_rv_cyc.delete();
        lsu_rv_data.delete();
        if_rv_cyc.delete();
        if_rv_data.delete();
    endtask

    task automatic lsu_op(input logic we, input logic [14:0] a, input logic [127:0] d, output int gc);
        lsu_req = 1'b1; lsu_we = we; lsu_addr = a; lsu_wdata = d; gc = -1;
        for (int i = 0; i < 20 && gc < 0; i++) begin
            @(negedge clock);
            if (lsu_gnt) gc = cyc;
            step();
        end
        lsu_req = 1'b0; lsu_we = 1'b0;
        if (gc < 0) check("lsu_gnt_timeout", 128'd0, 128'd1);
    endtask

    task automatic if_op(input logic [14:0] a, output int gc);
        if_req = 1'b1; if_addr = a; gc = -1;
        for (int i = 0; i < 20 && gc < 0; i++) begin
            @(negedge clock);
            if (if_gnt) gc = cyc;
            step();
        end
        if_req = 1'b0;
        if (gc < 0) check("if_gnt_timeout", 128'd0, 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int g, g2, fg;
        int lg_q[$];
        int fg_q[$];
        logic exp_l;
        logic [15:0] a16;

        // reset state with requests present
        lsu_req = 1'b1; if_req = 1'b1;
        step(); step();
        check("rst_lsu_gnt", 128'(lsu_gnt), 128'd0);
        check("rst_if_gnt", 128'(if_gnt), 128'd0);
        check("rst_lsu_rvalid", 128'(lsu_rvalid), 128'd0);
        check("rst_if_rvalid", 128'(if_rvalid), 128'd0);
        check("rst_lsu_rdata", lsu_rdata, 128'd0);
        lsu_req = 1'b0; if_req = 1'b0;
        step();
        reset = 1'b1;
        step();

        // 1: store then load with unaligned byte offset
        clear_logs();
        lsu_op(1'b1, 15'h0040, V1, g);
        lsu_op(1'b0, 15'h004F, '0, g);
        repeat (10) step();
        check("t1_rv_count", 128'(lsu_rv_cyc.size()), 128'd1);
        check("t1_if_rv_count", 128'(if_rv_cyc.size()), 128'd0);
        if (lsu_rv_cyc.size() > 0) begin
            check("t1_latency", 128'(lsu_rv_cyc[0] - g), 128'd6);
            check("t1_data", lsu_rv_data[0], V1);
        end

        // 2: back-to-back store/load at top quadword
        clear_logs();
        lsu_op(1'b1, 15'h7FF0, V2, g);
        lsu_op(1'b0, 15'h7FF0, '0, g2);
        repeat (10) step();
        check("t2_consecutive", 128'(g2 - g), 128'd1);
        check("t2_rv_count", 128'(lsu_rv_cyc.size()), 128'd1);
        if (lsu_rv_data.size() > 0) check("t2_data", lsu_rv_data[0], V2);

        // 3: arbitration with both ports held
        lsu_op(1'b1, 15'h0200, DL, g);
        lsu_op(1'b1, 15'h0300, DF, g);
        clear_logs();
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 15'h0200;
        if_req = 1'b1; if_addr = 15'h0300;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            exp_l = (i % 3) != 2;
            check($sformatf("t3_lsu_gnt_%0d", i), 128'(lsu_gnt), 128'(exp_l));
            check($sformatf("t3_if_gnt_%0d", i), 128'(if_gnt), 128'(!exp_l));
            if (lsu_gnt) lg_q.push_back(cyc);
            if (if_gnt) fg_q.push_back(cyc);
            step();
        end
        lsu_req = 1'b0; if_req = 1'b0;
        repeat (10) step();
        check("t3_lsu_rv_count", 128'(lsu_rv_cyc.size()), 128'd6);
        check("t3_if_rv_count", 128'(if_rv_cyc.size()), 128'd2);
        for (int k = 0; k < lsu_rv_cyc.size() && k < lg_q.size(); k++) begin
            check($sformatf("t3_lsu_lat_%0d", k), 128'(lsu_rv_cyc[k] - lg_q[k]), 128'd6);
            check($sformatf("t3_lsu_data_%0d", k), lsu_rv_data[k], DL);
        end
        for (int k = 0; k < if_rv_cyc.size() && k < fg_q.size(); k++) begin
            check($sformatf("t3_if_lat_%0d", k), 128'(if_rv_cyc[k] - fg_q[k]), 128'd6);
            check($sformatf("t3_if_data_%0d", k), if_rv_data[k], DF);
        end

        // 4: flush kills in-flight fetch, LSU load survives, fetch with flush not granted
        clear_logs();
        if_req = 1'b1; if_addr = 15'h0100;
        @(negedge clock);
        check("t4_if_gnt", 128'(if_gnt), 128'd1);
        fg = cyc;
        step();
        if_req = 1'b0;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 15'h0200;
        @(negedge clock);
        check("t4_lsu_gnt", 128'(lsu_gnt), 128'd1);
        g = cyc;
        step();
        lsu_req = 1'b0;
        flush = 1'b1; if_req = 1'b1; if_addr = 15'h0300;
        @(negedge clock);
        check("t4_flush_cycle", 128'(cyc - fg), 128'd2);
        check("t4_if_gnt_flush", 128'(if_gnt), 128'd0);
        step();
        flush = 1'b0; if_req = 1'b0;
        repeat (10) step();
        check("t4_if_rv_count", 128'(if_rv_cyc.size()), 128'd0);
        check("t4_lsu_rv_count", 128'(lsu_rv_cyc.size()), 128'd1);
        if (lsu_rv_cyc.size() > 0) begin
            check("t4_lsu_lat", 128'(lsu_rv_cyc[0] - g), 128'd6);
            check("t4_lsu_data", lsu_rv_data[0], DL);
        end

        // 5: reset with four loads in flight; a store offered during reset is dropped
        for (int k = 0; k < 4; k++) lsu_op(1'b1, 15'(15'h0400 + 16 * k), {4{32'hC0DE0000 + 32'(k)}}, g);
        for (int k = 0; k < 4; k++) lsu_op(1'b0, 15'(15'h0400 + 16 * k), '0, g);
        reset = 1'b0;
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 15'h0400; lsu_wdata = '1;
        #1;
        clear_logs();
        check("t5_lsu_gnt", 128'(lsu_gnt), 128'd0);
        check("t5_if_gnt", 128'(if_gnt), 128'd0);
        check("t5_lsu_rvalid", 128'(lsu_rvalid), 128'd0);
        check("t5_if_rvalid", 128'(if_rvalid), 128'd0);
        check("t5_lsu_rdata", lsu_rdata, 128'd0);
        check("t5_if_rdata", if_rdata, 128'd0);
        step();
        lsu_req = 1'b0; lsu_we = 1'b0;
        reset = 1'b1;
        repeat (12) step();
        check("t5_no_lsu_rv", 128'(lsu_rv_cyc.size()), 128'd0);
        check("t5_no_if_rv", 128'(if_rv_cyc.size()), 128'd0);
        lsu_op(1'b0, 15'h0400, '0, g);
        lsu_op(1'b0, 15'h0430, '0, g);
        repeat (10) step();
        check("t5_rv_count", 128'(lsu_rv_cyc.size()), 128'd2);
        if (lsu_rv_data.size() > 1) begin
            check("t5_data0", lsu_rv_data[0], {4{32'hC0DE0000}});
            check("t5_data3", lsu_rv_data[1], {4{32'hC0DE0003}});
        end

        // 6: address wrap; out-of-range bit truncated to quadword 0x0010
        clear_logs();
        lsu_op(1'b1, 15'h0010, X6, g);
        a16 = 16'h8010;
        lsu_op(1'b0, a16[14:0], '0, g);
        if_op(15'h001F, fg);
        repeat (10) step();
        check("t6_lsu_count", 128'(lsu_rv_cyc.size()), 128'd1);
        check("t6_if_count", 128'(if_rv_cyc.size()), 128'd1);
        if (lsu_rv_data.size() > 0) check("t6_lsu_data", lsu_rv_data[0], X6);
        if (if_rv_data.size() > 0) begin
            check("t6_if_data", if_rv_data[0], X6);
            check("t6_if_lat", 128'(if_rv_cyc[0] - fg), 128'd6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
